// File: rtl/bytecode_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : bytecode_fetch
//  Description : Bytecode prefetcher. Streams bytes from a synchronous program
//                memory into a 2-entry FIFO, stops at the terminator byte,
//                and supports fetch redirects, abort and address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module bytecode_fetch #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] HALT_BYTE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  output logic [7:0]        instr_byte,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              halted,
  output logic              wrapped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_faddr;      // next address to issue
  logic [ADDR_W-1:0] r_ret_addr;   // address of the read returning this cycle
  logic              r_inflight;   // a read was issued last cycle
  logic              r_halt_seen;
  logic              r_wrapped;
  logic [1:0]        r_count;
  logic [7:0]        r_byte0;
  logic [7:0]        r_byte1;
  logic [ADDR_W-1:0] r_pc0;
  logic [ADDR_W-1:0] r_pc1;

  logic              w_in_fetch;
  logic              w_jump;
  logic              w_pop;
  logic              w_halt_hit;
  logic              w_push;
  logic [2:0]        w_occ;

  // Datapath control: handshake, terminator detection and FIFO occupancy
  always_comb begin
    w_in_fetch = (r_state == S_FETCH);
    w_jump     = w_in_fetch && enable && jump_en;
    w_pop      = w_in_fetch && (r_count != 2'd0) && instr_ready;
    w_halt_hit = r_inflight && !r_halt_seen && (mem_rdata == HALT_BYTE);
    w_push     = r_inflight && !r_halt_seen && !w_halt_hit && !w_jump && enable;
    // A same-cycle pop frees its slot, which keeps one issue per cycle alive
    w_occ      = 3'(r_count) - 3'(w_pop) + 3'(r_inflight);
  end

  // FSM next state and state-derived outputs
  always_comb begin
    w_next      = r_state;
    mem_re      = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_FETCH;
      end
      S_FETCH: begin
        busy        = 1'b1;
        instr_valid = (r_count != 2'd0);
        mem_re      = enable && !jump_en && !r_halt_seen && !w_halt_hit && (w_occ < 3'd2);
        if (!enable)
          w_next = S_IDLE;
        else if (!jump_en && r_halt_seen && (r_count == 2'd0))
          w_next = S_HALT;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!enable) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Fetch address, in-flight tracking and 2-entry FIFO; jump and idle flush last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_faddr     <= '0;
      r_ret_addr  <= '0;
      r_inflight  <= 1'b0;
      r_halt_seen <= 1'b0;
      r_wrapped   <= 1'b0;
      r_count     <= 2'd0;
      r_byte0     <= 8'd0;
      r_byte1     <= 8'd0;
      r_pc0       <= '0;
      r_pc1       <= '0;
    end else begin
      r_inflight <= mem_re;
      if (mem_re) begin
        r_faddr    <= r_faddr + c_addr_one;
        r_ret_addr <= r_faddr;
        if (r_faddr == c_last_addr) r_wrapped <= 1'b1;
      end
      if (w_halt_hit) r_halt_seen <= 1'b1;

      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_byte0 <= mem_rdata;
            r_pc0   <= r_ret_addr;
          end else begin
            r_byte1 <= mem_rdata;
            r_pc1   <= r_ret_addr;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_byte0 <= r_byte1;
          r_pc0   <= r_pc1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_byte0 <= r_byte1;
            r_pc0   <= r_pc1;
            r_byte1 <= mem_rdata;
            r_pc1   <= r_ret_addr;
          end else begin
            r_byte0 <= mem_rdata;
            r_pc0   <= r_ret_addr;
          end
        end
        default: ;
      endcase

      // Redirect discards everything buffered or returning and restarts issue
      if (w_jump) begin
        r_faddr     <= jump_addr;
        r_inflight  <= 1'b0;
        r_count     <= 2'd0;
        r_halt_seen <= 1'b0;
      end

      // Entering or staying in IDLE rewinds the fetcher to address 0
      if (w_next == S_IDLE) begin
        r_faddr     <= '0;
        r_inflight  <= 1'b0;
        r_count     <= 2'd0;
        r_halt_seen <= 1'b0;
        r_wrapped   <= 1'b0;
      end
    end
  end

  assign mem_addr   = r_faddr;
  assign instr_byte = r_byte0;
  assign instr_pc   = r_pc0;
  assign wrapped    = r_wrapped;

endmodule
`default_nettype wire

// File: doc/bytecode_fetch.md
BYTECODE_FETCH -- requirements
Module: bytecode_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, program memory address width (1024 bytes).
REQ-002 The block SHALL have parameter HALT_BYTE, default 8'hFF, program terminator value.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port enable, input, 1, run request; level-sensitive.
REQ-006 The block SHALL have port mem_re, output, 1, memory read strobe.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W, memory read address.
REQ-008 The block SHALL have port mem_rdata, input, 8, read data, valid exactly one cycle after the mem_re cycle.
REQ-009 The block SHALL have port jump_en, input, 1, fetch redirect strobe.
REQ-010 The block SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-011 The block SHALL have port instr_valid, output, 1, instr_byte holds a valid bytecode byte.
REQ-012 The block SHALL have port instr_byte, output, 8, head-of-buffer bytecode byte.
REQ-013 The block SHALL have port instr_ready, input, 1, consumer accepts instr_byte.
REQ-014 The block SHALL have port instr_pc, output, ADDR_W, memory address of instr_byte.
REQ-015 The block SHALL have ports busy, halted and wrapped, each output, 1: fetching, terminator reached, address wrap occurred (sticky).

Function
REQ-016 The FSM SHALL have states IDLE, FETCH and HALT.
REQ-017 IDLE SHALL move to FETCH on the first edge with enable=1; the fetch address SHALL then be 0.
REQ-018 In FETCH, mem_re SHALL assert whenever buffered count plus in-flight reads is below 2; each issue SHALL advance the fetch address by 1.
REQ-019 The fetch address SHALL wrap modulo 2^ADDR_W, from 1023 to 0; wrapped SHALL set on that wrap and hold until reset or IDLE.
REQ-020 Returned data SHALL enter a 2-entry FIFO together with its address; throughput SHALL be 1 byte/cycle with instr_ready held high.
REQ-021 Minimum latency from IDLE->FETCH to the first instr_valid SHALL be 2 cycles: issue in cycle 0, data in cycle 1, valid in cycle 2.
REQ-022 Handshake: a byte SHALL transfer on a cycle with instr_valid=1 and instr_ready=1.
REQ-023 While instr_valid=1 and instr_ready=0, instr_byte and instr_pc SHALL hold stable.
REQ-024 A push and a pop on the same cycle SHALL leave the count unchanged.
REQ-025 A returned byte equal to HALT_BYTE SHALL NOT be pushed; issuing SHALL stop; any in-flight read issued after it SHALL be discarded.
REQ-026 After HALT_BYTE has been seen and the FIFO has drained, the FSM SHALL enter HALT.
REQ-027 In HALT: halted=1, busy=0, mem_re=0; HALT SHALL exit to IDLE only when enable=0.
REQ-028 jump_en=1 in FETCH SHALL flush the FIFO and in-flight reads and clear the terminator-seen flag; the next cycle SHALL issue a read at jump_addr.
REQ-029 jump_en SHALL be ignored in IDLE and HALT.
REQ-030 jump_en SHALL take priority over a simultaneous pop and a simultaneous push.
REQ-031 enable=0 in FETCH SHALL abort to IDLE next edge and flush all buffered and in-flight data.
REQ-032 busy SHALL equal (state==FETCH).
REQ-033 instr_valid SHALL be 0 outside FETCH.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, empty FIFO, no in-flight read, fetch address 0, and all of mem_re, instr_valid, busy, halted and wrapped 0.
REQ-035 instr_byte, instr_pc and mem_addr SHALL reset to 0.
REQ-036 Reset mid-fetch SHALL discard data returning on the cycle after release.

Verification
REQ-037 Memory {8'h12, 8'h34, 8'hFF}, enable=1, instr_ready=1 -> 12@0 then 34@1 on consecutive cycles; halted=1 two cycles later; no further mem_re.
REQ-038 Same program, instr_ready=0 for 5 cycles -> instr_byte holds 12 stable, at most 2 reads outstanding; both bytes delivered in order after release.
REQ-039 Memory all 8'h00 except mem[3]=FF, jump_en with jump_addr=1020 while fetching -> bytes at 1020..1023 then 0,1,2; wrapped=1; halted after byte @2.
REQ-040 jump_en in the same cycle as a pop, target 5 -> popped byte consumed, next delivered instr_pc=5, no stale bytes.
REQ-041 rst pulse mid-fetch at address 7 -> all outputs 0 asynchronously; after release with enable=1, fetch restarts at address 0.
REQ-042 In HALT, toggle enable 1->0->1 -> HALT->IDLE->FETCH; program re-delivered from address 0 with wrapped cleared.
